// File: rtl/gpo_timed_scheduler.sv
// gpo_timed_scheduler
//   Timestamped instruction sequencer in front of a GPO core. Entries of
//   {timestamp, 128-bit word} are queued in a FIFO. A free-running timeline
//   counter advances while in RUN. The head entry is issued to the core once
//   its timestamp has been reached and the core is not busy. Late issue and
//   FIFO overflow are reported through sticky flags.
//
// Ports
//   CLK100MHZ       system clock
//   reset           synchronous, active-high
//   start / stop    IDLE->RUN / RUN->IDLE pulses (stop wins when both are high)
//   counter_clear   zero the timeline counter
//   flush           empty the FIFO, suppress issue this cycle
//   wr_en, wr_timestamp, wr_data   push a new entry
//   busy            GPO core busy; holds the head entry
//   error_clear     clear sticky errors
//   counter_matched one-cycle issue strobe, gpo_in valid alongside it
//   gpo_in          word presented to the core (holds between issues)
//   timeline        current counter value
//   running         high in RUN
//   fifo_full, fifo_empty, fifo_count   FIFO status (count includes the head)
//   late_error, late_timestamp          sticky late-issue flag, first late ts
//   overflow_error  sticky: write attempted while full
module gpo_timed_scheduler #(
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_WIDTH  = 64
) (
  input  logic                           CLK100MHZ,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           stop,
  input  logic                           counter_clear,
  input  logic                           flush,
  input  logic                           wr_en,
  input  logic [CNT_WIDTH-1:0]           wr_timestamp,
  input  logic [127:0]                   wr_data,
  input  logic                           busy,
  input  logic                           error_clear,
  output logic                           counter_matched,
  output logic [127:0]                   gpo_in,
  output logic [CNT_WIDTH-1:0]           timeline,
  output logic                           running,
  output logic                           fifo_full,
  output logic                           fifo_empty,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_count,
  output logic                           late_error,
  output logic [CNT_WIDTH-1:0]           late_timestamp,
  output logic                           overflow_error
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t                 state_reg;
  logic [CNT_WIDTH-1:0]   counter_reg;
  logic                   matched_reg;
  logic [127:0]           gpo_reg;
  logic                   late_error_reg;
  logic [CNT_WIDTH-1:0]   late_ts_reg;
  logic                   overflow_reg;

  // Storage array plus a registered head entry. fifo_count covers both, so an
  // entry loaded into the head register still counts as occupying the FIFO.
  logic [CNT_WIDTH-1:0]   ts_mem   [FIFO_DEPTH];
  logic [127:0]           data_mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr_reg;
  logic [AW-1:0]          rd_ptr_reg;
  logic [CW-1:0]          count_reg;
  logic                   head_valid_reg;
  logic [CNT_WIDTH-1:0]   head_ts_reg;
  logic [127:0]           head_data_reg;

  logic full;
  logic empty;
  logic push;
  logic issue;
  logic head_load;
  logic late_set;
  logic overflow_set;

  assign full  = (count_reg == CW'(FIFO_DEPTH));
  assign empty = (count_reg == '0);

  // Writes coincident with a pop are still judged against the pre-pop count.
  assign push         = wr_en & ~full & ~flush;
  assign overflow_set = wr_en & full & ~flush;

  // head_valid_reg implies the FIFO is not empty. After a pop the head register
  // is refilled one cycle later, which enforces the one-cycle issue gap.
  assign issue = (state_reg == RUN) & head_valid_reg & ~busy & ~flush &
                 (head_ts_reg <= counter_reg);
  assign late_set = issue & (head_ts_reg < counter_reg);

  // With the head register empty, every counted entry sits in the array.
  assign head_load = ~head_valid_reg & ~empty & ~flush;

  always_ff @(posedge CLK100MHZ) begin
    if (push) begin
      ts_mem[wr_ptr_reg]   <= wr_timestamp;
      data_mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    if (reset || flush) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      head_valid_reg <= 1'b0;
      head_ts_reg    <= '0;
      head_data_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (head_load) begin
        head_valid_reg <= 1'b1;
        head_ts_reg    <= ts_mem[rd_ptr_reg];
        head_data_reg  <= data_mem[rd_ptr_reg];
        rd_ptr_reg     <= rd_ptr_reg + 1'b1;
      end
      if (issue) head_valid_reg <= 1'b0;
      count_reg <= count_reg + CW'(push) - CW'(issue);
    end
  end

  // Run/idle FSM, timeline counter and the issue strobe to the core.
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      state_reg   <= IDLE;
      counter_reg <= '0;
      matched_reg <= 1'b0;
      gpo_reg     <= '0;
    end else begin
      case (state_reg)
        IDLE: if (start && !stop) state_reg <= RUN;
        RUN:  if (stop) state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
      if (counter_clear)
        counter_reg <= '0;
      else if (state_reg == RUN)
        counter_reg <= counter_reg + 1'b1;
      matched_reg <= issue;
      if (issue) gpo_reg <= head_data_reg;
    end
  end

  // Sticky errors; a new error in the same cycle as error_clear wins.
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      late_error_reg <= 1'b0;
      late_ts_reg    <= '0;
      overflow_reg   <= 1'b0;
    end else begin
      if (late_set) begin
        late_error_reg <= 1'b1;
        if (!late_error_reg || error_clear) late_ts_reg <= head_ts_reg;
      end else if (error_clear) begin
        late_error_reg <= 1'b0;
        late_ts_reg    <= '0;
      end
      if (overflow_set)
        overflow_reg <= 1'b1;
      else if (error_clear)
        overflow_reg <= 1'b0;
    end
  end

  assign counter_matched = matched_reg;
  assign gpo_in          = gpo_reg;
  assign timeline        = counter_reg;
  assign running         = (state_reg == RUN);
  assign fifo_full       = full;
  assign fifo_empty      = empty;
  assign fifo_count      = count_reg;
  assign late_error      = late_error_reg;
  assign late_timestamp  = late_ts_reg;
  assign overflow_error  = overflow_reg;

endmodule

// File: tb/tb_gpo_timed_scheduler.sv
module tb_gpo_timed_scheduler;

  logic         CLK100MHZ = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0, stop = 1'b0, counter_clear = 1'b0, flush = 1'b0;
  logic         wr_en = 1'b0, busy = 1'b0, error_clear = 1'b0;
  logic [63:0]  wr_timestamp = '0;
  logic [127:0] wr_data = '0;
  logic         counter_matched;
  logic [127:0] gpo_in;
  logic [63:0]  timeline;
  logic         running, fifo_full, fifo_empty;
  logic [4:0]   fifo_count;
  logic         late_error;
  logic [63:0]  late_timestamp;
  logic         overflow_error;

  gpo_timed_scheduler #(.FIFO_DEPTH(16), .CNT_WIDTH(64)) dut (
    .CLK100MHZ(CLK100MHZ), .reset(reset), .start(start), .stop(stop),
    .counter_clear(counter_clear), .flush(flush), .wr_en(wr_en),
    .wr_timestamp(wr_timestamp), .wr_data(wr_data), .busy(busy),
    .error_clear(error_clear), .counter_matched(counter_matched),
    .gpo_in(gpo_in), .timeline(timeline), .running(running),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .fifo_count(fifo_count),
    .late_error(late_error), .late_timestamp(late_timestamp),
    .overflow_error(overflow_error)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [63:0]  strobe_tl[$];
  logic [127:0] strobe_data[$];

  typedef struct {
    logic         st, sp, wr, cc;
    logic [63:0]  ts;
    logic [127:0] data;
    logic         exp_matched;
    logic [127:0] exp_gpo;
    logic [63:0]  exp_tl;
    logic         exp_run;
    logic [4:0]   exp_cnt;
    logic         exp_empty;
  } vec_t;

  vec_t vt[13];

  function automatic vec_t mk(logic st, logic sp, logic wr, logic cc,
                              logic [63:0] ts, logic [127:0] d, logic em,
                              logic [127:0] eg, logic [63:0] etl, logic er,
                              logic [4:0] ecnt, logic ee);
    vec_t v;
    v.st = st; v.sp = sp; v.wr = wr; v.cc = cc; v.ts = ts; v.data = d;
    v.exp_matched = em; v.exp_gpo = eg; v.exp_tl = etl; v.exp_run = er;
    v.exp_cnt = ecnt; v.exp_empty = ee;
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // One clock: outputs sampled 1 ns after the rising edge, strobes logged.
  task automatic step();
    @(posedge CLK100MHZ);
    #1;
    if (counter_matched) begin
      strobe_tl.push_back(timeline);
      strobe_data.push_back(gpo_in);
    end
  endtask

  task automatic push_entry(input logic [63:0] ts, input logic [127:0] d);
    wr_en = 1'b1; wr_timestamp = ts; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic clear_log();
    strobe_tl.delete();
    strobe_data.delete();
  endtask

  initial begin
    logic hit;

    // Basic issue timing, table-driven (one row per clock).
    vt[0]  = mk(0,0,1,0, 64'd5, 128'hA5, 0, 128'h0,  64'd0, 0, 5'd1, 0);
    vt[1]  = mk(0,0,0,0, 64'd0, 128'h0,  0, 128'h0,  64'd0, 0, 5'd1, 0);
    vt[2]  = mk(1,0,0,0, 64'd0, 128'h0,  0, 128'h0,  64'd0, 1, 5'd1, 0);
    vt[3]  = mk(0,0,0,0, 64'd0, 128'h0,  0, 128'h0,  64'd1, 1, 5'd1, 0);
    vt[4]  = mk(0,0,0,0, 64'd0, 128'h0,  0, 128'h0,  64'd2, 1, 5'd1, 0);
    vt[5]  = mk(0,0,0,0, 64'd0, 128'h0,  0, 128'h0,  64'd3, 1, 5'd1, 0);
    vt[6]  = mk(0,0,0,0, 64'd0, 128'h0,  0, 128'h0,  64'd4, 1, 5'd1, 0);
    vt[7]  = mk(0,0,0,0, 64'd0, 128'h0,  0, 128'h0,  64'd5, 1, 5'd1, 0);
    vt[8]  = mk(0,0,0,0, 64'd0, 128'h0,  1, 128'hA5, 64'd6, 1, 5'd0, 1);
    vt[9]  = mk(0,0,0,0, 64'd0, 128'h0,  0, 128'hA5, 64'd7, 1, 5'd0, 1);
    vt[10] = mk(0,1,0,0, 64'd0, 128'h0,  0, 128'hA5, 64'd8, 0, 5'd0, 1);
    vt[11] = mk(0,0,0,0, 64'd0, 128'h0,  0, 128'hA5, 64'd8, 0, 5'd0, 1);
    vt[12] = mk(0,0,0,1, 64'd0, 128'h0,  0, 128'hA5, 64'd0, 0, 5'd0, 1);

    // Reset state
    repeat (3) step();
    chk("rst_matched", 128'(counter_matched), 128'd0);
    chk("rst_gpo", gpo_in, 128'd0);
    chk("rst_timeline", 128'(timeline), 128'd0);
    chk("rst_running", 128'(running), 128'd0);
    chk("rst_full", 128'(fifo_full), 128'd0);
    chk("rst_empty", 128'(fifo_empty), 128'd1);
    chk("rst_count", 128'(fifo_count), 128'd0);
    chk("rst_late", 128'(late_error), 128'd0);
    chk("rst_late_ts", 128'(late_timestamp), 128'd0);
    chk("rst_overflow", 128'(overflow_error), 128'd0);
    reset = 1'b0;

    // Test 1: single entry ts=5
    for (int i = 0; i < 13; i++) begin
      start = vt[i].st; stop = vt[i].sp; wr_en = vt[i].wr; counter_clear = vt[i].cc;
      wr_timestamp = vt[i].ts; wr_data = vt[i].data;
      step();
      chk($sformatf("t1_matched[%0d]", i), 128'(counter_matched), 128'(vt[i].exp_matched));
      chk($sformatf("t1_gpo[%0d]", i), gpo_in, vt[i].exp_gpo);
      chk($sformatf("t1_timeline[%0d]", i), 128'(timeline), 128'(vt[i].exp_tl));
      chk($sformatf("t1_running[%0d]", i), 128'(running), 128'(vt[i].exp_run));
      chk($sformatf("t1_count[%0d]", i), 128'(fifo_count), 128'(vt[i].exp_cnt));
      chk($sformatf("t1_empty[%0d]", i), 128'(fifo_empty), 128'(vt[i].exp_empty));
    end
    start = 0; stop = 0; wr_en = 0; counter_clear = 0;
    chk("t1_late", 128'(late_error), 128'd0);

    // Test 2: back-to-back due entries, one-cycle issue gap
    push_entry(64'd3, 128'd1);
    push_entry(64'd4, 128'd2);
    push_entry(64'd5, 128'd3);
    step();
    start = 1'b1; step(); start = 1'b0;
    clear_log();
    repeat (20) step();
    chk("t2_nstrobes", 128'(strobe_tl.size()), 128'd3);
    chk("t2_tl0", 128'(strobe_tl[0]), 128'd4);
    chk("t2_tl1", 128'(strobe_tl[1]), 128'd6);
    chk("t2_tl2", 128'(strobe_tl[2]), 128'd8);
    chk("t2_d0", strobe_data[0], 128'd1);
    chk("t2_d1", strobe_data[1], 128'd2);
    chk("t2_d2", strobe_data[2], 128'd3);
    chk("t2_late", 128'(late_error), 128'd1);
    chk("t2_late_ts", 128'(late_timestamp), 128'd4);
    stop = 1'b1; step(); stop = 1'b0;

    // Test 3: busy holds the head, issues late when busy drops
    error_clear = 1'b1; counter_clear = 1'b1; step();
    error_clear = 1'b0; counter_clear = 1'b0;
    chk("t3_late_cleared", 128'(late_error), 128'd0);
    chk("t3_late_ts_cleared", 128'(late_timestamp), 128'd0);
    push_entry(64'd10, 128'h10);
    start = 1'b1; step(); start = 1'b0;
    clear_log();
    for (int i = 0; i < 40; i++) begin
      busy = (timeline >= 64'd8) && (timeline <= 64'd14);
      step();
    end
    busy = 1'b0;
    chk("t3_nstrobes", 128'(strobe_tl.size()), 128'd1);
    chk("t3_tl", 128'(strobe_tl[0]), 128'd16);
    chk("t3_data", strobe_data[0], 128'h10);
    chk("t3_late", 128'(late_error), 128'd1);
    chk("t3_late_ts", 128'(late_timestamp), 128'd10);
    stop = 1'b1; step(); stop = 1'b0;

    // Test 4: overflow with 17 writes while idle, then drain
    for (int i = 0; i < 17; i++) push_entry(64'd0, 128'(100 + i));
    step();
    chk("t4_full", 128'(fifo_full), 128'd1);
    chk("t4_count", 128'(fifo_count), 128'd16);
    chk("t4_overflow", 128'(overflow_error), 128'd1);
    start = 1'b1; step(); start = 1'b0;
    clear_log();
    repeat (60) step();
    stop = 1'b1; step(); stop = 1'b0;
    chk("t4_nstrobes", 128'(strobe_data.size()), 128'd16);
    for (int i = 0; i < 16; i++)
      chk($sformatf("t4_d%0d", i), strobe_data[i], 128'(100 + i));
    chk("t4_empty", 128'(fifo_empty), 128'd1);

    // Test 5: flush while running, coincident write dropped; then error_clear
    push_entry(64'd1000, 128'd7);
    push_entry(64'd1000, 128'd8);
    push_entry(64'd1000, 128'd9);
    start = 1'b1; step(); start = 1'b0;
    repeat (3) step();
    chk("t5_count_pre", 128'(fifo_count), 128'd3);
    flush = 1'b1; wr_en = 1'b1; wr_timestamp = 64'd0; wr_data = 128'hEE;
    clear_log();
    step();
    flush = 1'b0; wr_en = 1'b0;
    chk("t5_empty", 128'(fifo_empty), 128'd1);
    chk("t5_count", 128'(fifo_count), 128'd0);
    chk("t5_running", 128'(running), 128'd1);
    repeat (5) step();
    chk("t5_nstrobes", 128'(strobe_tl.size()), 128'd0);
    chk("t5_late_pre", 128'(late_error), 128'd1);
    chk("t5_overflow_pre", 128'(overflow_error), 128'd1);
    error_clear = 1'b1; step(); error_clear = 1'b0;
    chk("t5_late", 128'(late_error), 128'd0);
    chk("t5_late_ts", 128'(late_timestamp), 128'd0);
    chk("t5_overflow", 128'(overflow_error), 128'd0);
    stop = 1'b1; step(); stop = 1'b0;

    // Test 6: stop mid-operation retains the head and freezes the timeline
    counter_clear = 1'b1; step(); counter_clear = 1'b0;
    push_entry(64'd25, 128'h66);
    start = 1'b1; step(); start = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!hit && timeline == 64'd19) begin
        stop = 1'b1; step(); stop = 1'b0;
        hit = 1'b1;
      end else begin
        step();
      end
    end
    chk("t6_stop_tl", 128'(timeline), 128'd20);
    chk("t6_running", 128'(running), 128'd0);
    clear_log();
    repeat (50) step();
    chk("t6_idle_nstrobes", 128'(strobe_tl.size()), 128'd0);
    chk("t6_idle_tl", 128'(timeline), 128'd20);
    chk("t6_count", 128'(fifo_count), 128'd1);
    start = 1'b1; step(); start = 1'b0;
    repeat (20) step();
    chk("t6_nstrobes", 128'(strobe_tl.size()), 128'd1);
    chk("t6_tl", 128'(strobe_tl[0]), 128'd26);
    chk("t6_data", strobe_data[0], 128'h66);
    chk("t6_late", 128'(late_error), 128'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
